// File: rtl/qspi_sram_ctrl.sv
// QSPI master for 23LC1024-class serial SRAMs: switches the device to SQI after reset, then serves
// single-word reads/writes. Define QSPI_RSTIO_EN to send RSTIO (0xFF) ahead of EQIO during init.
module qspi_sram_ctrl #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 16,
    parameter int CLK_DIV        = 1,
    parameter int CS_HIGH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  init_done,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  cs_n,
    output logic                  sck,
    output logic                  sio_oe,
    output logic [3:0]            sio_o,
    input  logic [3:0]            sio_i
);

    localparam int DATA_NIB   = DATA_WIDTH / 4;
    localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
    localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
    localparam int GAP_W      = $clog2(CS_HIGH_CYCLES + 1);

    typedef enum logic [3:0] {
        ST_INIT,
        ST_RSTIO,
        ST_RSTIO_GAP,
        ST_INIT_EQIO,
        ST_INIT_GAP,
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_RDATA,
        ST_WDATA,
        ST_CS_GAP
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [DIV_W-1:0]      div_cnt;
    logic [3:0]            phase_cnt;
    logic [3:0]            phase_len;
    logic [GAP_W-1:0]      gap_cnt;
    logic [63:0]           tx_sr;
    logic [63:0]           tx_load;
    logic [23:0]           byte_addr;
    logic [DATA_WIDTH-1:0] rx_sr;
    logic                  we_q;
    logic                  in_slot;
    logic                  slot_end;
    logic                  sample_now;
    logic                  sck_level;
    logic                  phase_last;
    logic                  phase_done;
    logic                  gap_state;
    logic                  gap_last;
    logic                  accept;

    // A nibble slot is 2*CLK_DIV clk cycles: sck low in the first half, high in the second.
    assign slot_end   = (div_cnt == DIV_W'(2 * CLK_DIV - 1));
    assign sample_now = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign sck_level  = (div_cnt >= DIV_W'(CLK_DIV));
    assign gap_last   = (gap_cnt == GAP_W'(CS_HIGH_CYCLES - 1));
    assign phase_last = (phase_cnt == phase_len - 4'd1);
    assign phase_done = in_slot && slot_end && phase_last;

    // Handshake: a request transfers on a clk edge where req_valid && req_ready; req_ready is high
    // only in IDLE after init, so at most one transaction is ever outstanding.
    assign accept = req_valid && req_ready;

    always_comb begin
        in_slot   = 1'b0;
        gap_state = 1'b0;
        phase_len = 4'd1;
        case (state_q)
            ST_RSTIO:     begin in_slot = 1'b1; phase_len = 4'd2; end
            ST_INIT_EQIO: begin in_slot = 1'b1; phase_len = 4'd8; end
            ST_CMD:       begin in_slot = 1'b1; phase_len = 4'd2; end
            ST_ADDR:      begin in_slot = 1'b1; phase_len = 4'd6; end
            ST_DUMMY:     begin in_slot = 1'b1; phase_len = 4'd2; end
            ST_RDATA:     begin in_slot = 1'b1; phase_len = 4'(DATA_NIB); end
            ST_WDATA:     begin in_slot = 1'b1; phase_len = 4'(DATA_NIB); end
            ST_RSTIO_GAP: gap_state = 1'b1;
            ST_INIT_GAP:  gap_state = 1'b1;
            ST_CS_GAP:    gap_state = 1'b1;
            default:      ;
        endcase
    end

    // Outgoing frame, left-aligned: command, 24-bit byte address, then write data.
    always_comb begin
        byte_addr                     = '0;
        byte_addr[ADDR_WIDTH-1:0]     = req_addr;
        byte_addr                     = byte_addr << BYTE_SHIFT;
        tx_load                       = '0;
        tx_load[63:56]                = req_we ? 8'h02 : 8'h03;
        tx_load[55:32]                = byte_addr;
        tx_load[31 -: DATA_WIDTH]     = req_wdata;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        cs_n      = 1'b1;
        sck       = 1'b0;
        sio_oe    = 1'b0;
        sio_o     = 4'b1000;
        case (state_q)
            ST_INIT: begin
`ifdef QSPI_RSTIO_EN
                state_d = ST_RSTIO;
`else
                state_d = ST_INIT_EQIO;
`endif
            end
            ST_RSTIO: begin
                cs_n   = 1'b0;
                sck    = sck_level;
                sio_oe = 1'b1;
                sio_o  = 4'hF;
                if (phase_done) state_d = ST_RSTIO_GAP;
            end
            ST_RSTIO_GAP: begin
                if (gap_last) state_d = ST_INIT_EQIO;
            end
            ST_INIT_EQIO: begin
                // Still in SPI mode: one bit per slot on SIO0 with HOLD_N kept high.
                cs_n   = 1'b0;
                sck    = sck_level;
                sio_oe = 1'b1;
                sio_o  = {1'b1, 2'b00, tx_sr[63]};
                if (phase_done) state_d = ST_INIT_GAP;
            end
            ST_INIT_GAP: begin
                if (gap_last) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                req_ready = init_done;
                if (accept) state_d = ST_CMD;
            end
            ST_CMD: begin
                cs_n   = 1'b0;
                sck    = sck_level;
                sio_oe = 1'b1;
                sio_o  = tx_sr[63:60];
                if (phase_done) state_d = ST_ADDR;
            end
            ST_ADDR: begin
                cs_n   = 1'b0;
                sck    = sck_level;
                sio_oe = 1'b1;
                sio_o  = tx_sr[63:60];
                if (phase_done) state_d = we_q ? ST_WDATA : ST_DUMMY;
            end
            ST_DUMMY: begin
                cs_n = 1'b0;
                sck  = sck_level;
                if (phase_done) state_d = ST_RDATA;
            end
            ST_RDATA: begin
                cs_n = 1'b0;
                sck  = sck_level;
                if (phase_done) state_d = ST_CS_GAP;
            end
            ST_WDATA: begin
                cs_n   = 1'b0;
                sck    = sck_level;
                sio_oe = 1'b1;
                sio_o  = tx_sr[63:60];
                if (phase_done) state_d = ST_CS_GAP;
            end
            ST_CS_GAP: begin
                if (gap_last) state_d = ST_IDLE;
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_cnt   <= '0;
            phase_cnt <= '0;
            gap_cnt   <= '0;
            tx_sr     <= {8'h38, 56'h0};
            rx_sr     <= '0;
            we_q      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            init_done <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;

            if (in_slot) begin
                div_cnt <= slot_end ? '0 : div_cnt + 1'b1;
                if (slot_end) phase_cnt <= phase_last ? 4'd0 : phase_cnt + 4'd1;
            end

            if (gap_state) gap_cnt <= gap_last ? '0 : gap_cnt + 1'b1;

            if (state_q == ST_IDLE && accept) begin
                tx_sr <= tx_load;
                we_q  <= req_we;
            end else if (slot_end && state_q == ST_INIT_EQIO) begin
                tx_sr <= {tx_sr[62:0], 1'b0};
            end else if (slot_end && (state_q == ST_CMD || state_q == ST_ADDR ||
                                      state_q == ST_WDATA)) begin
                tx_sr <= {tx_sr[59:0], 4'h0};
            end

            // Device data is sampled on the edge that raises sck.
            if (state_q == ST_RDATA && sample_now) rx_sr <= {rx_sr[DATA_WIDTH-5:0], sio_i};

            if (state_q == ST_RDATA && phase_done) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= rx_sr;
            end

            if (state_q == ST_INIT_GAP && gap_last) init_done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_qspi_sram_ctrl.sv
// Directed bench for qspi_sram_ctrl: default instance for init/write/read/reset/back-to-back,
// plus a CLK_DIV=3, DATA_WIDTH=32 instance for slow-clock reads.
`timescale 1ns/1ps
module tb_qspi_sram_ctrl;

    localparam int DW   = 16;
    localparam int AW   = 16;
    localparam int CSH  = 2;
    localparam int DW4  = 32;
    localparam int DIV4 = 3;
`ifdef QSPI_RSTIO_EN
    localparam int RST_NIB     = 2;
    localparam int INIT_EXTRA  = 4 + CSH;
    localparam int INIT_EXTRA4 = 4 * DIV4 + CSH;
`else
    localparam int RST_NIB     = 0;
    localparam int INIT_EXTRA  = 0;
    localparam int INIT_EXTRA4 = 0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          reset;
    logic          init_done;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          cs_n;
    logic          sck;
    logic          sio_oe;
    logic [3:0]    sio_o;
    logic [3:0]    sio_i;

    logic           reset4;
    logic           init_done4;
    logic           req_valid4;
    logic           req_ready4;
    logic           req_we4;
    logic [AW-1:0]  req_addr4;
    logic [DW4-1:0] req_wdata4;
    logic           rsp_valid4;
    logic [DW4-1:0] rsp_rdata4;
    logic           cs_n4;
    logic           sck4;
    logic           sio_oe4;
    logic [3:0]     sio_o4;
    logic [3:0]     sio_i4;

    qspi_sram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLK_DIV(1), .CS_HIGH_CYCLES(CSH)) u_dut (
        .clk(clk), .reset(reset), .init_done(init_done),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .cs_n(cs_n), .sck(sck), .sio_oe(sio_oe), .sio_o(sio_o), .sio_i(sio_i)
    );

    qspi_sram_ctrl #(.DATA_WIDTH(DW4), .ADDR_WIDTH(AW), .CLK_DIV(DIV4), .CS_HIGH_CYCLES(CSH)) u_dut4 (
        .clk(clk), .reset(reset4), .init_done(init_done4),
        .req_valid(req_valid4), .req_ready(req_ready4), .req_we(req_we4),
        .req_addr(req_addr4), .req_wdata(req_wdata4),
        .rsp_valid(rsp_valid4), .rsp_rdata(rsp_rdata4),
        .cs_n(cs_n4), .sck(sck4), .sio_oe(sio_oe4), .sio_o(sio_o4), .sio_i(sio_i4)
    );

    // ---------------- SQI device models ----------------
    // Nibbles are counted on sck rising; read data appears after cmd(2)+addr(6)+dummy(2).
    logic [DW-1:0]  rd_word  = '0;
    logic [DW4-1:0] rd_word4 = '0;
    int             nib_cnt  = 0;
    int             nib_cnt4 = 0;
    logic [3:0]     nib_q[$];
    logic [3:0]     nib_q4[$];

    always @(posedge sck or posedge cs_n) begin
        if (cs_n) nib_cnt <= 0;
        else begin
            nib_cnt <= nib_cnt + 1;
            if (sio_oe) nib_q.push_back(sio_o);
        end
    end

    always @(posedge sck4 or posedge cs_n4) begin
        if (cs_n4) nib_cnt4 <= 0;
        else begin
            nib_cnt4 <= nib_cnt4 + 1;
            if (sio_oe4) nib_q4.push_back(sio_o4);
        end
    end

    always_comb begin
        sio_i = 4'h0;
        if (nib_cnt >= 10 && nib_cnt < 10 + DW / 4)
            sio_i = rd_word[(DW / 4 - 1 - (nib_cnt - 10)) * 4 +: 4];
    end

    always_comb begin
        sio_i4 = 4'h0;
        if (nib_cnt4 >= 10 && nib_cnt4 < 10 + DW4 / 4)
            sio_i4 = rd_word4[(DW4 / 4 - 1 - (nib_cnt4 - 10)) * 4 +: 4];
    end

    // ---------------- response monitors ----------------
    int             rsp_cnt  = 0;
    int             rsp_cyc  = -1;
    logic [DW-1:0]  rsp_dat  = '0;
    int             rsp_cnt4 = 0;
    int             rsp_cyc4 = -1;
    logic [DW4-1:0] rsp_dat4 = '0;

    always @(negedge clk) begin
        if (rsp_valid) begin
            rsp_cnt <= rsp_cnt + 1;
            rsp_cyc <= cyc;
            rsp_dat <= rsp_rdata;
        end
        if (rsp_valid4) begin
            rsp_cnt4 <= rsp_cnt4 + 1;
            rsp_cyc4 <= cyc;
            rsp_dat4 <= rsp_rdata4;
        end
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic oe_hist  [0:255];
    logic sck_hist [0:255];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [63:0] pack_nibs(input logic [3:0] q[$], input int base, input int n);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v = {v[59:0], (base + i < q.size()) ? q[base + i] : 4'h0};
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_init(input int r, output int lat);
        lat = -1;
        for (int g = 0; g < 300; g++) begin
            @(negedge clk);
            if (init_done) begin
                lat = cyc - r;
                break;
            end
        end
    endtask

    // Returns at the negedge of cycle T+1 with the acceptance cycle T.
    task automatic send(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        output int t_acc);
        int guard;
        guard = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        while (!req_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        t_acc = (guard < 200) ? cyc : -1000;
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = AW'($urandom_range(0, 65535));
        req_wdata = DW'($urandom_range(0, 65535));
    endtask

    task automatic wait_rise(input int t, output int rise);
        rise = -1;
        for (int g = 0; g < 400; g++) begin
            if (cyc - t >= 0 && cyc - t < 256) begin
                oe_hist[cyc - t]  = sio_oe;
                sck_hist[cyc - t] = sck;
            end
            if (cs_n) begin
                rise = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int r, lat, t, t2, rise, rise2, base, rc;
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        reset4     = 1'b0;
        req_valid4 = 1'b0;
        req_we4    = 1'b0;
        req_addr4  = '0;
        req_wdata4 = '0;

        // Init: reset low 3 cycles, then EQIO 0x38 with HOLD_N high.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {cs_n, sck, sio_oe, sio_o, req_ready, rsp_valid, init_done},
              {1'b1, 1'b0, 1'b0, 4'b1000, 3'b000});
        check("reset_rdata", rsp_rdata, 16'h0000);
        reset = 1'b1;
        r = cyc;
        wait_init(r, lat);
        check("init_latency", lat, 19 + INIT_EXTRA);
        check("init_ready", req_ready, 1'b1);
        check("init_nib_count", nib_q.size(), 8 + RST_NIB);
        check("init_eqio_bits", pack_nibs(nib_q, RST_NIB, 8), 32'h8899_9888);

        // Write 0x1234 <= 0xBEEF.
        rd_word = 16'hBEEF;
        base = nib_q.size();
        rc = rsp_cnt;
        send(1'b1, 16'h1234, 16'hBEEF, t);
        check("wr_busy", req_ready, 1'b0);
        wait_rise(t, rise);
        @(negedge clk);
        check("wr_cs_rise", rise - t, 25);
        check("wr_oe_last", oe_hist[24], 1'b1);
        check("wr_nib_count", nib_q.size() - base, 12);
        check("wr_nibbles", pack_nibs(nib_q, base, 12), 48'h0200_2468_BEEF);
        check("wr_no_rsp", rsp_cnt - rc, 0);

        // Read 0x1234, device returns 0xBEEF.
        base = nib_q.size();
        rc = rsp_cnt;
        send(1'b0, 16'h1234, 16'h0000, t);
        wait_rise(t, rise);
        @(negedge clk);
        check("rd_cs_rise", rise - t, 29);
        check("rd_rsp_cycle", rsp_cyc - t, 29);
        check("rd_rsp_count", rsp_cnt - rc, 1);
        check("rd_data", rsp_dat, 16'hBEEF);
        check("rd_oe_addr", oe_hist[16], 1'b1);
        check("rd_oe_dummy", oe_hist[17], 1'b0);
        check("rd_oe_data", oe_hist[28], 1'b0);
        check("rd_nib_count", nib_q.size() - base, 8);
        check("rd_nibbles", pack_nibs(nib_q, base, 8), 32'h0300_2468);
        check("rd_rdata_held", rsp_rdata, 16'hBEEF);

        // Reset during ADDR abandons the read; init repeats; boundary address read follows.
        rc = rsp_cnt;
        send(1'b0, 16'h1234, 16'h0000, t);
        repeat (7) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_outputs", {cs_n, sck, sio_oe, req_ready, init_done}, 5'b10000);
        @(negedge clk);
        reset = 1'b1;
        r = cyc;
        wait_init(r, lat);
        check("reinit_latency", lat, 19 + INIT_EXTRA);
        check("abort_no_rsp", rsp_cnt - rc, 0);
        rd_word = 16'h5A3C;
        base = nib_q.size();
        send(1'b0, 16'hFFFF, 16'h0000, t);
        wait_rise(t, rise);
        @(negedge clk);
        check("max_addr_cs_rise", rise - t, 29);
        check("max_addr_data", rsp_dat, 16'h5A3C);
        check("max_addr_nibbles", pack_nibs(nib_q, base, 8), 32'h0301_FFFE);

        // Back-to-back reads with req_valid held high.
        for (int g = 0; g < 50; g++) begin
            if (req_ready) break;
            @(negedge clk);
        end
        rd_word = 16'h1357;
        rc = rsp_cnt;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 16'h0042;
        t = cyc;
        check("b2b_first_ready", req_ready, 1'b1);
        @(negedge clk);
        check("b2b_busy", req_ready, 1'b0);
        wait_rise(t, rise);
        t2 = -1000;
        for (int g = 0; g < 50; g++) begin
            if (req_ready) begin
                t2 = cyc;
                break;
            end
            check("b2b_gap_cs", cs_n, 1'b1);
            @(negedge clk);
        end
        check("b2b_second_accept", t2 - rise, CSH);
        @(negedge clk);
        req_valid = 1'b0;
        check("b2b_second_cs", cs_n, 1'b0);
        wait_rise(t2, rise2);
        @(negedge clk);
        check("b2b_second_rise", rise2 - t2, 29);
        check("b2b_rsp_count", rsp_cnt - rc, 2);
        check("b2b_data", rsp_dat, 16'h1357);

        // CLK_DIV=3, DATA_WIDTH=32 instance: read word address 0.
        @(negedge clk);
        reset4 = 1'b1;
        r = cyc;
        lat = -1;
        for (int g = 0; g < 400; g++) begin
            @(negedge clk);
            if (init_done4) begin
                lat = cyc - r;
                break;
            end
        end
        check("div3_init_latency", lat, 51 + INIT_EXTRA4);
        rd_word4 = 32'hCAFE_F00D;
        base = nib_q4.size();
        rc = rsp_cnt4;
        req_valid4 = 1'b1;
        t = cyc;
        check("div3_ready", req_ready4, 1'b1);
        @(negedge clk);
        req_valid4 = 1'b0;
        rise = -1;
        for (int g = 0; g < 400; g++) begin
            if (cyc - t >= 0 && cyc - t < 256) sck_hist[cyc - t] = sck4;
            if (cs_n4) begin
                rise = cyc;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        check("div3_cs_rise", rise - t, 109);
        check("div3_sck_shape", {sck_hist[1], sck_hist[2], sck_hist[3], sck_hist[4],
                                 sck_hist[5], sck_hist[6], sck_hist[7]}, 7'b0001110);
        check("div3_nibbles", pack_nibs(nib_q4, base, 8), 32'h0300_0000);
        check("div3_rsp_cycle", rsp_cyc4 - t, 109);
        check("div3_rsp_count", rsp_cnt4 - rc, 1);
        check("div3_data", rsp_dat4, 32'hCAFE_F00D);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
